// File: rtl/lot_pkg.sv
// Shared types and sensor-pattern constants for the parking-lot occupancy monitor.
package lot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    BAD
  } gate_state_t;

  // Sensor pattern {a, b}: a is the outer sensor, b the inner one.
  localparam logic [1:0] P_CLR = 2'b00;
  localparam logic [1:0] P_A   = 2'b10;
  localparam logic [1:0] P_B   = 2'b01;
  localparam logic [1:0] P_AB  = 2'b11;

  function automatic int unsigned net_width(input int unsigned gates);
    return $clog2(gates) + 2;
  endfunction

endpackage

// File: rtl/gate_seq.sv
// Single-gate strict enter/exit sequence detector with back-out and error lock-out.
module gate_seq
  import lot_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit,
  output logic seq_err
);

  gate_state_t state_q, state_d;
  logic [1:0]  p;
  logic        enter_c, exit_c, err_c;

  assign p = {a, b};

  // Next-state and event decode; any unlisted pattern drops into BAD once.
  always_comb begin
    state_d = state_q;
    enter_c = 1'b0;
    exit_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: case (p)
        P_CLR:   state_d = IDLE;
        P_A:     state_d = EN1;
        P_B:     state_d = EX1;
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EN1: case (p)
        P_A:     state_d = EN1;
        P_AB:    state_d = EN2;
        P_CLR:   state_d = IDLE;
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EN2: case (p)
        P_AB:    state_d = EN2;
        P_B:     state_d = EN3;
        P_A:     state_d = EN1;
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EN3: case (p)
        P_B:     state_d = EN3;
        P_AB:    state_d = EN2;
        P_CLR:   begin state_d = IDLE; enter_c = 1'b1; end
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EX1: case (p)
        P_B:     state_d = EX1;
        P_AB:    state_d = EX2;
        P_CLR:   state_d = IDLE;
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EX2: case (p)
        P_AB:    state_d = EX2;
        P_A:     state_d = EX3;
        P_B:     state_d = EX1;
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      EX3: case (p)
        P_A:     state_d = EX3;
        P_AB:    state_d = EX2;
        P_CLR:   begin state_d = IDLE; exit_c = 1'b1; end
        default: begin state_d = BAD; err_c = 1'b1; end
      endcase
      BAD: begin
        if (p == P_CLR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state_q <= state_d;
      enter   <= enter_c;
      exit    <= exit_c;
      seq_err <= err_c;
    end
  end

endmodule

// File: rtl/lot_monitor.sv
// Multi-gate parking-lot monitor: per-gate sequence detectors feeding a
// shared saturating occupancy counter with sticky overflow/underflow flags.
module lot_monitor
  import lot_pkg::*;
#(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 25,
  parameter int unsigned CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  input  logic                 clr_flags,
  output logic [NUM_GATES-1:0] enter,
  output logic [NUM_GATES-1:0] exit,
  output logic [NUM_GATES-1:0] seq_err,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 unf
);

  localparam int unsigned NET_W = net_width(NUM_GATES);
  localparam int unsigned SUM_W = ((CNT_W > NET_W) ? CNT_W : NET_W) + 2;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_seq u_gate (
      .clk     (clk),
      .reset   (reset),
      .a       (a[g]),
      .b       (b[g]),
      .enter   (enter[g]),
      .exit    (exit[g]),
      .seq_err (seq_err[g])
    );
  end

  logic signed [NET_W-1:0] net_c;
  logic signed [SUM_W-1:0] sum_c;
  logic                    ovf_set_c, unf_set_c;

  // Entries and exits of the same cycle cancel before the clamp is applied.
  always_comb begin
    net_c = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      net_c = net_c + $signed(NET_W'(enter[i])) - $signed(NET_W'(exit[i]));
    end
    sum_c     = $signed(SUM_W'(count)) + SUM_W'(net_c);
    ovf_set_c = sum_c > $signed(SUM_W'(CAPACITY));
    unf_set_c = sum_c[SUM_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (ovf_set_c)      count <= CNT_W'(CAPACITY);
      else if (unf_set_c) count <= '0;
      else                count <= CNT_W'(sum_c);
      ovf <= ovf_set_c | (ovf & ~clr_flags);
      unf <= unf_set_c | (unf & ~clr_flags);
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_lot_monitor.sv
// Bench for lot_monitor: directed scenarios plus random sensor walks checked
// every cycle against a ring-progress model of car movement.
module tb_lot_monitor;

  localparam int NG  = 2;
  localparam int CAP = 3;
  localparam int CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr_flags = 1'b0;
  logic [NG-1:0] a = '0;
  logic [NG-1:0] b = '0;
  logic [NG-1:0] enter, exit, seq_err;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;

  always #5 clk = ~clk;

  lot_monitor #(.NUM_GATES(NG), .CAPACITY(CAP), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .clr_flags (clr_flags),
    .enter     (enter),
    .exit      (exit),
    .seq_err   (seq_err),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // A car walks around the pattern ring 00 -> 10 -> 11 -> 01 -> 00 when
  // entering, and the opposite way when exiting.
  function automatic logic [1:0] ring(input int k);
    case (((k % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Model: signed progress along the ring; +4 is a full entry, -4 a full exit.
  int            prog [NG];
  bit            mbad [NG];
  logic [NG-1:0] m_enter, m_exit, m_err;
  int            m_count;
  bit            m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin : model
    int            s, np;
    logic [1:0]    p;
    logic [NG-1:0] ne, nx, nr;
    bit            nb;
    if (reset) begin
      for (int g = 0; g < NG; g++) begin
        prog[g] <= 0;
        mbad[g] <= 1'b0;
      end
      m_enter <= '0; m_exit <= '0; m_err <= '0;
      m_count <= 0;  m_ovf <= 1'b0; m_unf <= 1'b0;
    end else begin
      s = m_count + $countones(m_enter) - $countones(m_exit);
      m_count <= (s > CAP) ? CAP : ((s < 0) ? 0 : s);
      m_ovf   <= (s > CAP) || (m_ovf && !clr_flags);
      m_unf   <= (s < 0)   || (m_unf && !clr_flags);
      ne = '0; nx = '0; nr = '0;
      for (int g = 0; g < NG; g++) begin
        p  = {a[g], b[g]};
        np = prog[g];
        nb = mbad[g];
        if (nb) begin
          if (p == 2'b00) nb = 1'b0;
        end else if (p == ring(np)) begin
          np = np;
        end else if (p == ring(np + 1)) begin
          np = np + 1;
        end else if (p == ring(np - 1)) begin
          np = np - 1;
        end else begin
          nb = 1'b1; nr[g] = 1'b1; np = 0;
        end
        if (np == 4)  begin ne[g] = 1'b1; np = 0; end
        if (np == -4) begin nx[g] = 1'b1; np = 0; end
        prog[g] <= np;
        mbad[g] <= nb;
      end
      m_enter <= ne; m_exit <= nx; m_err <= nr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("enter",   enter,   m_enter);
      check("exit",    exit,    m_exit);
      check("seq_err", seq_err, m_err);
      check("count",   count,   m_count);
      check("full",    full,    m_count == CAP);
      check("empty",   empty,   m_count == 0);
      check("ovf",     ovf,     m_ovf);
      check("unf",     unf,     m_unf);
    end
  end

  task automatic step(input logic [1:0] p0, input logic [1:0] p1);
    a = {p1[1], p0[1]};
    b = {p1[0], p0[0]};
    @(negedge clk);
  endtask

  task automatic entry0();
    step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00); step(2'b00, 2'b00);
  endtask

  task automatic exit0();
    step(2'b01, 2'b00); step(2'b11, 2'b00); step(2'b10, 2'b00); step(2'b00, 2'b00);
  endtask

  int rp [NG];

  initial begin
    #1 reset = 1'b1;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);

    // Entry then exit on gate 0
    step(2'b00, 2'b00);
    entry0();
    check("enter0_pulse", enter, 2'b01);
    check("cnt_lag",      count, 0);
    step(2'b00, 2'b00);
    check("enter0_gone",  enter, 2'b00);
    check("cnt_entry",    count, 1);
    check("model_cnt1",   m_count, 1);
    exit0();
    check("exit0_pulse",  exit, 2'b01);
    step(2'b00, 2'b00);
    check("cnt_exit",     count, 0);

    // Back-out on gate 1
    step(2'b00, 2'b10); step(2'b00, 2'b11); step(2'b00, 2'b10); step(2'b00, 2'b00);
    check("backout_pulse", {seq_err, enter}, 4'b0000);
    step(2'b00, 2'b00);
    check("backout_cnt", count, 0);

    // Illegal transition on gate 1, lock-out, recovery
    step(2'b00, 2'b10); step(2'b00, 2'b01);
    check("err1_pulse", seq_err, 2'b10);
    step(2'b00, 2'b11);
    check("err_once", seq_err, 2'b00);
    step(2'b00, 2'b01); step(2'b00, 2'b00);
    step(2'b00, 2'b10); step(2'b00, 2'b11); step(2'b00, 2'b01); step(2'b00, 2'b00);
    check("recover_enter", enter, 2'b10);
    step(2'b00, 2'b00);
    check("recover_cnt", count, 1);

    // Simultaneous entry on gate 0 and exit on gate 1
    step(2'b10, 2'b01); step(2'b11, 2'b11); step(2'b01, 2'b10); step(2'b00, 2'b00);
    check("sim_pulses", {exit, enter}, 4'b1001);
    step(2'b00, 2'b00);
    check("sim_cnt",   count, 1);
    check("sim_flags", {ovf, unf}, 2'b00);

    // Saturation at both ends, then flag clear
    repeat (4) entry0();
    step(2'b00, 2'b00);
    check("sat_cnt",  count, 3);
    check("sat_full", full, 1);
    check("sat_ovf",  ovf, 1);
    check("model_sat", m_count, 3);
    repeat (5) exit0();
    step(2'b00, 2'b00);
    check("unf_cnt",   count, 0);
    check("unf_empty", empty, 1);
    check("unf_flags", {ovf, unf}, 2'b11);
    clr_flags = 1'b1;
    step(2'b00, 2'b00);
    clr_flags = 1'b0;
    check("clr_flags", {ovf, unf}, 2'b00);

    // Asynchronous reset between clock edges
    entry0();
    step(2'b00, 2'b00);
    check("pre_rst_cnt", count, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_pulse", {enter, exit, seq_err}, 6'b0);
    @(negedge clk);
    reset = 1'b0;

    // Reset while gate 0 is mid-entry: the tail of the sequence must not count
    step(2'b10, 2'b00); step(2'b11, 2'b00);
    reset = 1'b1;
    #2 reset = 1'b0;
    step(2'b01, 2'b00); step(2'b00, 2'b00);
    check("mid_rst_enter", enter, 2'b00);
    step(2'b00, 2'b00);
    check("mid_rst_cnt", count, 0);

    // Random walks around the ring, alternating net-entry and net-exit bias
    for (int g = 0; g < NG; g++) rp[g] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int g = 0; g < NG; g++) begin
        int r, fwd;
        r   = int'($urandom_range(99));
        fwd = ((c / 500) % 2 == 0) ? 45 : 15;
        if (r < 2)            rp[g] = int'($urandom_range(3));
        else if (r < 2 + fwd) rp[g] = (rp[g] + 1) % 4;
        else if (r < 62)      rp[g] = (rp[g] + 3) % 4;
        a[g] = ring(rp[g]) >> 1;
        b[g] = ring(rp[g]) & 2'b01;
      end
      clr_flags = ($urandom_range(99) < 2);
      @(negedge clk);
    end
    clr_flags = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
